// File: rtl/audio_dma_pkg.sv
// Shared definitions for the audio sample DMA: register map, bit positions and FSM encoding.
package audio_dma_pkg;

  localparam logic [2:0] REG_BASE   = 3'd0;
  localparam logic [2:0] REG_LEN    = 3'd1;
  localparam logic [2:0] REG_MATCH  = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_FLUSH_BIT   = 1;
  localparam int unsigned STATUS_OVF_BIT   = 16;
  localparam int unsigned STATUS_EMPTY_BIT = 17;

  typedef enum logic {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } dma_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for audio samples with combinational head and a synchronous flush.
module sample_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PtrOne;
      if (w_pop_ok)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/sample_dma.sv
// Wishbone DMA master writing audio samples into a circular RAM buffer, with a CPU
// configuration window on dbus and done/match interrupt pulses.
module sample_dma
  import audio_dma_pkg::*;
#(
  parameter int unsigned       AWIDTH     = 8,
  parameter logic [AWIDTH-1:0] ADDR       = 8'h60,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       IDX_W      = 12
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        wb_dbus_cyc,
  input  logic        wb_dbus_we,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  output logic        ack,
  output logic [31:0] rdt,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        dma_cyc,
  output logic        dma_we,
  output logic [3:0]  dma_sel,
  output logic [31:0] dma_adr,
  output logic [31:0] dma_dat,
  input  logic        dma_ack,
  output logic        dma_done,
  output logic        dma_match
);

  localparam logic [IDX_W-1:0] IdxOne = 1;

  dma_state_e       r_state;
  dma_state_e       w_state_next;
  logic             r_ack;
  logic             r_acked;
  logic [31:0]      r_base;
  logic [IDX_W-1:0] r_len;
  logic [IDX_W-1:0] r_match;
  logic [IDX_W-1:0] r_index;
  logic             r_en;
  logic             r_overflow;
  logic             r_flush_pend;
  logic             r_done;
  logic             r_match_p;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;

  logic             w_sel;
  logic [2:0]       w_idx;
  logic             w_wr;
  logic [31:0]      w_rdata;
  logic             w_flush_req;
  logic             w_flush_any;
  logic             w_flush_now;
  logic             w_write_ack;
  logic             w_start;
  logic             w_wrap;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [31:0]      w_fifo_head;
  logic             w_push;
  logic             w_ovf_set;
  logic             w_unused_adr;

  assign w_sel        = wb_dbus_cyc && (wb_dbus_adr[31 -: AWIDTH] == ADDR);
  assign w_idx        = wb_dbus_adr[4:2];
  assign w_wr         = r_ack && w_sel && wb_dbus_we;
  assign w_unused_adr = ^{wb_dbus_adr[31-AWIDTH:5], wb_dbus_adr[1:0]};

  assign ack = r_ack && w_sel;
  assign rdt = (r_ack && w_sel && !wb_dbus_we) ? w_rdata : '0;

  // A flush requested mid-transfer is held until the ack so the bus write is never cut short.
  assign w_flush_req = w_wr && (w_idx == REG_CTRL) && wb_dbus_dat[CTRL_FLUSH_BIT];
  assign w_flush_any = w_flush_req || r_flush_pend;
  assign w_write_ack = (r_state == StWrite) && dma_ack;
  assign w_flush_now = w_flush_any && ((r_state == StIdle) || w_write_ack);

  // Greater-or-equal compare lets a shrunk LEN wrap on the next completed write.
  assign w_wrap = (r_len == '0) || (r_index >= (r_len - IdxOne));

  assign w_push    = s_valid && r_en && (!w_fifo_full || w_write_ack) && !w_flush_now;
  assign w_ovf_set = s_valid && r_en && w_fifo_full && !w_write_ack;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (wb_clk),
    .i_rst_n (wb_rst_n),
    .i_push  (w_push),
    .i_pop   (w_write_ack),
    .i_flush (w_flush_now),
    .i_data  (s_data),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_BASE:   w_rdata = r_base;
      REG_LEN:    w_rdata[IDX_W-1:0] = r_len;
      REG_MATCH:  w_rdata[IDX_W-1:0] = r_match;
      REG_CTRL:   w_rdata[CTRL_EN_BIT] = r_en;
      REG_STATUS: begin
        w_rdata[IDX_W-1:0]        = r_index;
        w_rdata[STATUS_OVF_BIT]   = r_overflow;
        w_rdata[STATUS_EMPTY_BIT] = w_fifo_empty;
      end
      default:    w_rdata = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_fifo_empty && r_en && (r_len != '0) && !w_flush_any) begin
          w_state_next = StWrite;
          w_start      = 1'b1;
        end
      end
      StWrite: begin
        if (dma_ack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ack once per selected cycle; r_acked blocks re-assertion until cyc drops.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack   <= 1'b0;
      r_acked <= 1'b0;
    end else begin
      r_ack   <= w_sel && !r_ack && !r_acked;
      r_acked <= wb_dbus_cyc && (r_acked || r_ack);
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_base       <= '0;
      r_len        <= '0;
      r_match      <= '0;
      r_en         <= 1'b0;
      r_overflow   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_index      <= '0;
      r_done       <= 1'b0;
      r_match_p    <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
    end else begin
      if (w_wr && (w_idx == REG_BASE))  r_base  <= {wb_dbus_dat[31:2], 2'b00};
      if (w_wr && (w_idx == REG_LEN))   r_len   <= wb_dbus_dat[IDX_W-1:0];
      if (w_wr && (w_idx == REG_MATCH)) r_match <= wb_dbus_dat[IDX_W-1:0];
      if (w_wr && (w_idx == REG_CTRL))  r_en    <= wb_dbus_dat[CTRL_EN_BIT];

      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_wr && (w_idx == REG_STATUS) && wb_dbus_dat[STATUS_OVF_BIT]) begin
        r_overflow <= 1'b0;
      end

      r_flush_pend <= w_flush_any && !w_flush_now;

      if (w_flush_now) begin
        r_index <= '0;
      end else if (w_write_ack) begin
        r_index <= w_wrap ? '0 : r_index + IdxOne;
      end

      r_done    <= w_write_ack && w_wrap;
      r_match_p <= w_write_ack && (r_index == r_match);

      if (w_start) begin
        r_adr <= r_base + {{(30-IDX_W){1'b0}}, r_index, 2'b00};
        r_dat <= w_fifo_head;
      end
    end
  end

  assign dma_cyc   = (r_state == StWrite);
  assign dma_we    = dma_cyc;
  assign dma_sel   = dma_cyc ? 4'hf : 4'h0;
  assign dma_adr   = r_adr;
  assign dma_dat   = r_dat;
  assign dma_done  = r_done;
  assign dma_match = r_match_p;

endmodule

// File: tb/tb_sample_dma.sv
// Directed bench for sample_dma: CPU register accesses, a RAM-side ack responder and
// hand-computed expectations for addresses, data, pulses and status.
module tb_sample_dma;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        wb_dbus_cyc;
  logic        wb_dbus_we;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic        ack;
  logic [31:0] rdt;
  logic        s_valid;
  logic [31:0] s_data;
  logic        dma_cyc;
  logic        dma_we;
  logic [3:0]  dma_sel;
  logic [31:0] dma_adr;
  logic [31:0] dma_dat;
  logic        dma_ack;
  logic        dma_done;
  logic        dma_match;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_adr [$];
  logic [31:0] wr_dat [$];
  int          match_log [$];
  int          done_log [$];
  int          sel_bad = 0;
  int          ack_delay = 2;
  bit          ack_hold = 1'b0;
  int          wait_cnt = 0;

  always #5 wb_clk = ~wb_clk;

  sample_dma u_dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .wb_dbus_cyc (wb_dbus_cyc),
    .wb_dbus_we  (wb_dbus_we),
    .wb_dbus_adr (wb_dbus_adr),
    .wb_dbus_dat (wb_dbus_dat),
    .ack         (ack),
    .rdt         (rdt),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .dma_cyc     (dma_cyc),
    .dma_we      (dma_we),
    .dma_sel     (dma_sel),
    .dma_adr     (dma_adr),
    .dma_dat     (dma_dat),
    .dma_ack     (dma_ack),
    .dma_done    (dma_done),
    .dma_match   (dma_match)
  );

  // RAM-side responder: acks ack_delay cycles into each cycle and logs the completed write.
  always @(negedge wb_clk) begin
    if (dma_match) match_log.push_back(wr_adr.size());
    if (dma_done)  done_log.push_back(wr_adr.size());
    if (dma_ack) begin
      dma_ack  = 1'b0;
      wait_cnt = 0;
    end else if (dma_cyc && !ack_hold) begin
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        dma_ack = 1'b1;
        wr_adr.push_back(dma_adr);
        wr_dat.push_back(dma_dat);
        if (dma_sel != 4'hf || !dma_we) sel_bad++;
      end
    end else if (!dma_cyc) begin
      wait_cnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cpu_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wdat,
                          output logic [31:0] rdat);
    @(negedge wb_clk);
    wb_dbus_cyc = 1'b1;
    wb_dbus_we  = we;
    wb_dbus_adr = 32'h6000_0000 | {27'b0, idx, 2'b00};
    wb_dbus_dat = wdat;
    @(negedge wb_clk);
    check_eq("ack_latency", 32'(ack), 32'd1);
    rdat = rdt;
    @(negedge wb_clk);
    check_eq("ack_single", 32'(ack), 32'd0);
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
  endtask

  task automatic cpu_wr(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] dummy;
    cpu_xfer(1'b1, idx, d, dummy);
  endtask

  task automatic cpu_rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    cpu_xfer(1'b0, idx, 32'h0, r);
    check_eq(tag, r, exp);
  endtask

  task automatic send_sample(input logic [31:0] d);
    @(negedge wb_clk);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge wb_clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_cyc(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (dma_cyc) break;
      @(negedge wb_clk);
    end
    check_eq(tag, 32'(dma_cyc), 32'd1);
  endtask

  task automatic wait_writes(input string tag, input int n);
    for (int i = 0; i < 300; i++) begin
      if (wr_adr.size() >= n) break;
      @(negedge wb_clk);
    end
    check_eq(tag, 32'(wr_adr.size()), 32'(n));
  endtask

  task automatic clear_logs();
    wr_adr.delete();
    wr_dat.delete();
    match_log.delete();
    done_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    wb_rst_n    = 1'b0;
    wb_dbus_cyc = 1'b0;
    wb_dbus_we  = 1'b0;
    wb_dbus_adr = '0;
    wb_dbus_dat = '0;
    s_valid     = 1'b0;
    s_data      = '0;
    dma_ack     = 1'b0;
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);

    // Reset state
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_rdt", rdt, 32'h0);
    check_eq("rst_cyc", 32'(dma_cyc), 32'd0);
    check_eq("rst_sel", 32'(dma_sel), 32'd0);
    check_eq("rst_adr", dma_adr, 32'h0);
    check_eq("rst_pulses", 32'({dma_done, dma_match}), 32'd0);

    // 1. Config and readback
    cpu_wr(3'd0, 32'h0000_1003);
    cpu_rd_chk("base_lowbits", 3'd0, 32'h0000_1000);
    cpu_wr(3'd0, 32'h0000_1000);
    cpu_wr(3'd1, 32'd4);
    cpu_wr(3'd2, 32'd2);
    cpu_wr(3'd3, 32'd1);
    cpu_rd_chk("base", 3'd0, 32'h0000_1000);
    cpu_rd_chk("len", 3'd1, 32'd4);
    cpu_rd_chk("match", 3'd2, 32'd2);
    cpu_rd_chk("ctrl", 3'd3, 32'd1);
    cpu_rd_chk("status_init", 3'd4, 32'h0002_0000);
    cpu_wr(3'd5, 32'hFFFF_FFFF);
    cpu_rd_chk("unmapped", 3'd5, 32'h0);
    @(negedge wb_clk);
    wb_dbus_cyc = 1'b1;
    wb_dbus_adr = 32'h7000_0000;
    repeat (2) @(negedge wb_clk);
    check_eq("unselected_ack", 32'(ack), 32'd0);
    check_eq("unselected_rdt", rdt, 32'h0);
    wb_dbus_cyc = 1'b0;

    // 2. Basic write sequence
    clear_logs();
    for (int i = 0; i < 5; i++) send_sample(32'hA0 + 32'(i));
    wait_writes("t2_count", 5);
    begin
      logic [31:0] exp_adr [5];
      exp_adr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1000};
      for (int i = 0; i < 5; i++) begin
        check_eq($sformatf("t2_adr%0d", i), wr_adr[i], exp_adr[i]);
        check_eq($sformatf("t2_dat%0d", i), wr_dat[i], 32'hA0 + 32'(i));
      end
    end
    repeat (4) @(negedge wb_clk);
    check_eq("t2_match_cnt", 32'(match_log.size()), 32'd1);
    if (match_log.size() > 0) check_eq("t2_match_pos", 32'(match_log[0]), 32'd3);
    check_eq("t2_done_cnt", 32'(done_log.size()), 32'd1);
    if (done_log.size() > 0) check_eq("t2_done_pos", 32'(done_log[0]), 32'd4);
    check_eq("t2_sel_we", 32'(sel_bad), 32'd0);
    cpu_rd_chk("t2_status", 3'd4, 32'h0002_0001);

    // 3. Overflow
    clear_logs();
    ack_hold = 1'b1;
    for (int i = 0; i < 6; i++) send_sample(32'hB0 + 32'(i));
    cpu_rd_chk("t3_status_ovf", 3'd4, 32'h0001_0001);
    check_eq("t3_cyc_held", 32'(dma_cyc), 32'd1);
    check_eq("t3_adr_held", dma_adr, 32'h1004);
    check_eq("t3_dat_held", dma_dat, 32'hB0);
    ack_hold = 1'b0;
    wait_writes("t3_count", 4);
    repeat (20) @(negedge wb_clk);
    check_eq("t3_no_extra", 32'(wr_adr.size()), 32'd4);
    begin
      logic [31:0] exp_adr [4];
      exp_adr = '{32'h1004, 32'h1008, 32'h100C, 32'h1000};
      for (int i = 0; i < 4 && i < wr_adr.size(); i++) begin
        check_eq($sformatf("t3_adr%0d", i), wr_adr[i], exp_adr[i]);
        check_eq($sformatf("t3_dat%0d", i), wr_dat[i], 32'hB0 + 32'(i));
      end
    end
    cpu_rd_chk("t3_status_after", 3'd4, 32'h0003_0001);
    cpu_wr(3'd4, 32'h0001_0000);
    cpu_rd_chk("t3_ovf_clear", 3'd4, 32'h0002_0001);

    // 4. Disable mid-transfer
    clear_logs();
    ack_hold = 1'b1;
    send_sample(32'hC0);
    send_sample(32'hC1);
    wait_cyc("t4_cyc");
    cpu_wr(3'd3, 32'd0);
    check_eq("t4_not_aborted", 32'(dma_cyc), 32'd1);
    ack_hold = 1'b0;
    wait_writes("t4_count", 1);
    repeat (20) @(negedge wb_clk);
    check_eq("t4_no_new", 32'(wr_adr.size()), 32'd1);
    check_eq("t4_adr", wr_adr[0], 32'h1004);
    check_eq("t4_dat", wr_dat[0], 32'hC0);
    cpu_rd_chk("t4_status", 3'd4, 32'h0000_0002);
    send_sample(32'hC2);
    cpu_rd_chk("t4_ignored", 3'd4, 32'h0000_0002);

    // 5. Flush during a write with INDEX=3 and two samples queued
    clear_logs();
    cpu_wr(3'd3, 32'd1);
    wait_writes("t5_c1", 1);
    check_eq("t5_c1_adr", wr_adr[0], 32'h1008);
    ack_hold = 1'b1;
    send_sample(32'hD0);
    send_sample(32'hD1);
    wait_cyc("t5_cyc");
    cpu_rd_chk("t5_status_pre", 3'd4, 32'h0000_0003);
    cpu_wr(3'd3, 32'd3);
    check_eq("t5_not_aborted", 32'(dma_cyc), 32'd1);
    check_eq("t5_adr_held", dma_adr, 32'h100C);
    ack_hold = 1'b0;
    wait_writes("t5_d0", 2);
    repeat (20) @(negedge wb_clk);
    check_eq("t5_flushed", 32'(wr_adr.size()), 32'd2);
    check_eq("t5_d0_dat", wr_dat[1], 32'hD0);
    cpu_rd_chk("t5_status_post", 3'd4, 32'h0002_0000);
    cpu_rd_chk("t5_ctrl", 3'd3, 32'd1);
    send_sample(32'hE0);
    wait_writes("t5_e0", 3);
    check_eq("t5_e0_adr", wr_adr[2], 32'h1000);

    // LEN written below INDEX wraps on the next write
    cpu_wr(3'd1, 32'd1);
    done_log.delete();
    send_sample(32'hF0);
    wait_writes("len_f0", 4);
    send_sample(32'hF1);
    wait_writes("len_f1", 5);
    check_eq("len_f0_adr", wr_adr[3], 32'h1004);
    check_eq("len_f1_adr", wr_adr[4], 32'h1000);
    repeat (3) @(negedge wb_clk);
    check_eq("len_done_cnt", 32'(done_log.size()), 32'd2);
    cpu_rd_chk("len_status", 3'd4, 32'h0002_0000);

    // 32-bit address wrap
    cpu_wr(3'd0, 32'hFFFF_FFFC);
    cpu_wr(3'd1, 32'd4);
    send_sample(32'h60);
    send_sample(32'h61);
    wait_writes("awrap_count", 7);
    check_eq("awrap_adr0", wr_adr[5], 32'hFFFF_FFFC);
    check_eq("awrap_adr1", wr_adr[6], 32'h0000_0000);
    check_eq("awrap_dat1", wr_dat[6], 32'h61);

    // 6. Async reset mid-write with a CPU ack in flight
    ack_hold = 1'b1;
    send_sample(32'h70);
    wait_cyc("t6_cyc");
    @(negedge wb_clk);
    wb_dbus_cyc = 1'b1;
    wb_dbus_we  = 1'b0;
    wb_dbus_adr = 32'h6000_0000;
    @(negedge wb_clk);
    check_eq("t6_ack_pre", 32'(ack), 32'd1);
    wb_rst_n = 1'b0;
    #1;
    check_eq("t6_ack_drop", 32'(ack), 32'd0);
    check_eq("t6_cyc_drop", 32'(dma_cyc), 32'd0);
    check_eq("t6_sel_drop", 32'(dma_sel), 32'd0);
    check_eq("t6_pulses", 32'({dma_done, dma_match}), 32'd0);
    wb_dbus_cyc = 1'b0;
    ack_hold    = 1'b0;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    cpu_rd_chk("t6_base", 3'd0, 32'h0);
    cpu_rd_chk("t6_len", 3'd1, 32'h0);
    cpu_rd_chk("t6_match", 3'd2, 32'h0);
    cpu_rd_chk("t6_ctrl", 3'd3, 32'h0);
    cpu_rd_chk("t6_status", 3'd4, 32'h0002_0000);
    check_eq("t6_adr", dma_adr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_dma.md
Name: sample_dma

Overview:
- Wishbone DMA master that takes 32-bit audio samples from the audio pipeline and writes them into a circular buffer in dbus RAM.
- Sits directly upstream of ram_arb port B: its dma_* master signals feed the arbiter.
- It generates the dma_done and dma_match interrupt pulses consumed by irq_reg.
- The CPU configures it through a dbus slave window with the OR-bus convention: rdt and ack are 0 when not selected.

Parameters:
- ADDR, 8'h60, dbus select value compared against wb_dbus_adr[31:24].
- AWIDTH, 8, width of the address select field.
- FIFO_DEPTH, 4, sample FIFO depth (power of 2, ≥2).
- IDX_W, 12, width of buffer length and index registers (max 4095 words).

Ports:
- wb_clk  in  1  system clock.
- wb_rst_n  in  1  asynchronous active-low reset.
- wb_dbus_cyc  in  1  CPU bus cycle.
- wb_dbus_we  in  1  CPU write.
- wb_dbus_adr  in  32  CPU address.
- wb_dbus_dat  in  32  CPU write data.
- ack  out  1  slave ack.
- rdt  out  32  slave read data (0 unless acking a read).
- s_valid  in  1  sample strobe, single-cycle.
- s_data  in  32  sample word.
- dma_cyc  out  1  master cycle, to ram_arb b_cyc.
- dma_we  out  1  always 1 while dma_cyc.
- dma_sel  out  4  4'hf while dma_cyc, else 0.
- dma_adr  out  32  byte address.
- dma_dat  out  32  write data.
- dma_ack  in  1  master ack.
- dma_done  out  1  one-cycle pulse on buffer wrap.
- dma_match  out  1  one-cycle pulse when the match index is written.

Behaviour:
Reset:
- All outputs 0.
- Registers 0.
- FIFO empty.
- State IDLE.
Register map (selected when wb_dbus_cyc and adr[31:24]==ADDR; word index adr[4:2]):
- 0 BASE: RW, byte address; bits[1:0] forced 0.
- 1 LEN: RW, IDX_W bits, words in buffer.
- 2 MATCH: RW, IDX_W bits.
- 3 CTRL: RW, bit0 EN. Writing bit1=1 clears INDEX and flushes the FIFO (self-clearing, reads 0).
- 4 STATUS: RO. [IDX_W-1:0]=INDEX, bit16=OVERFLOW (sticky), bit17=FIFO empty. A write with bit16=1 clears OVERFLOW.
- Other indexes read 0; writes to them are ignored.
Slave handshake:
- ack is registered and asserted the cycle after cyc is first seen selected.
- ack is high for exactly 1 cycle and is not reasserted until cyc drops.
- Write side effects occur on the ack cycle.
- rdt is valid only on the ack cycle.
FIFO:
- s_valid while EN=1 and FIFO not full pushes s_data.
- s_valid while full sets OVERFLOW; the sample is dropped.
- s_valid while EN=0 is ignored.
- Push and pop in the same cycle are both allowed when full.
Master FSM:
- IDLE:
  - Move to WRITE only when FIFO not empty, EN=1 and LEN≠0.
  - On the transition, latch dma_adr = BASE + 4*INDEX and dma_dat = FIFO head.
  - Assert dma_cyc on the next cycle.
- WRITE:
  - Hold cyc, adr and dat stable until dma_ack.
  - On dma_ack: pop the FIFO, deassert cyc the following cycle, go to IDLE.
  - If INDEX == MATCH: pulse dma_match.
  - If INDEX == LEN-1: set INDEX=0 and pulse dma_done. Otherwise INDEX += 1.
  - dma_match and dma_done may pulse together.
- IDLE lasts at least 1 cycle between writes, so dma_cyc always drops for ≥1 cycle.
Boundary conditions:
- Clearing EN mid-WRITE does not abort the transfer: the current write completes; no new writes start.
- A CTRL flush during WRITE takes effect after the ack; INDEX ends at 0.
- LEN written below INDEX: the next completed write wraps (compare uses ≥ LEN-1).
- Address arithmetic is 32-bit and wraps modulo 2^32.
- wb_rst_n asserted mid-cycle drops dma_cyc immediately (asynchronous reset).

Decomposition:
- Shared package audio_dma_pkg:
  - Register index constants (REG_BASE..REG_STATUS).
  - CTRL/STATUS bit positions.
  - FSM state encoding.
- One sub-module: sample_fifo.
  - Synchronous FIFO of width 32 and depth FIFO_DEPTH.
  - Ports: push, pop, full, empty.
  - Head data available combinationally.

Test Plan:
1. Config and readback:
   - Stimulus: write BASE=0x0000_1000, LEN=4, MATCH=2, CTRL=1.
   - Response: each access acks exactly 1 cycle after cyc; reading back gives the same values; CTRL reads 1; STATUS reads 0x0002_0000.
2. Basic write sequence:
   - Stimulus: 5 samples 0xA0..0xA4, with dma_ack returned 2 cycles after cyc.
   - Response: writes to 0x1000, 0x1004, 0x1008, 0x100C, 0x1000.
   - dma_match pulses after the 0x1008 write.
   - dma_done pulses after the 0x100C write.
   - INDEX ends at 1; dma_sel=4'hf throughout.
3. Overflow:
   - Stimulus: hold dma_ack low; send 6 samples.
   - Response: FIFO holds the first 4 samples; OVERFLOW=1.
   - After releasing ack, exactly 4 writes occur, carrying the first 4 samples.
   - Writing STATUS bit16=1 clears OVERFLOW.
4. Disable mid-transfer:
   - Stimulus: clear EN while dma_cyc is high and ack is pending.
   - Response: the write completes on ack; no further dma_cyc, even though the FIFO is non-empty.
5. Flush:
   - Stimulus: with INDEX=3 and 2 samples queued, write CTRL=3.
   - Response: FIFO empties; INDEX=0; the next sample writes to BASE.
6. Async reset:
   - Stimulus: assert wb_rst_n low mid-WRITE.
   - Response: dma_cyc, ack and pulses drop in the same cycle; after reset is released, all registers read 0.
